// File: rtl/pw_candidate_gen.sv
// Brute-force candidate generator: enumerates every string over the charset for a
// configurable length range, LANES consecutive candidates per valid/ready beat.
module pw_candidate_gen #(
  parameter int unsigned MAX_LEN      = 8,
  parameter int unsigned CHARSET_SIZE = 62,
  parameter int unsigned LANES        = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  input  logic [3:0]                  cfg_min_len,
  input  logic [3:0]                  cfg_max_len,
  input  logic                        hit_in,
  output logic                        cand_valid,
  input  logic                        cand_ready,
  output logic [LANES*MAX_LEN*8-1:0]  cand_data,
  output logic [3:0]                  cand_len,
  output logic [LANES-1:0]            cand_mask,
  output logic                        busy,
  output logic                        done,
  output logic                        hit_stop,
  output logic                        cfg_err,
  output logic [63:0]                 count
);

  localparam int unsigned DW = (CHARSET_SIZE > 1) ? $clog2(CHARSET_SIZE) : 1;
  localparam int unsigned LW = MAX_LEN * 8;
  localparam logic [DW-1:0] DMAX = DW'(CHARSET_SIZE - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e        state_q;
  logic [DW-1:0] dig_q [MAX_LEN];   // index 0 is the least-significant (last) character
  logic [3:0]    cur_len_q;
  logic [3:0]    max_len_q;
  logic [63:0]   count_q;
  logic          hit_stop_q;
  logic          cfg_err_q;

  logic [DW-1:0] lane_dig [LANES+1][MAX_LEN];
  logic [LANES:0] lane_co;
  logic          inc_c;
  logic          run;
  logic          accept;
  logic          exhausted;
  logic          cfg_ok;
  logic [63:0]   pop;

  function automatic logic [7:0] sym(input logic [DW-1:0] d);
    logic [7:0] v;
    v = 8'(d);
    if (v < 8'd26)      return 8'd97 + v;
    else if (v < 8'd52) return 8'd65 + v - 8'd26;
    else                return 8'd48 + v - 8'd52;
  endfunction

  assign run       = (state_q == S_RUN);
  assign accept    = run && cand_ready;
  assign exhausted = lane_co[LANES];
  assign cfg_ok    = (cfg_min_len != 4'd0) && (cfg_min_len <= cfg_max_len) &&
                     (32'(cfg_max_len) <= MAX_LEN);

  // Entry LANES of the chain is the next base; its sticky carry flags length exhaustion,
  // which also covers the exact-fill case where every lane of the beat is valid.
  always_comb begin
    inc_c = 1'b0;
    for (int unsigned i = 0; i < MAX_LEN; i++) lane_dig[0][i] = dig_q[i];
    lane_co[0] = 1'b0;
    for (int unsigned k = 1; k <= LANES; k++) begin
      inc_c = 1'b1;
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        if (inc_c && (i < 32'(cur_len_q))) begin
          if (lane_dig[k-1][i] == DMAX) begin
            lane_dig[k][i] = '0;
          end else begin
            lane_dig[k][i] = lane_dig[k-1][i] + 1'b1;
            inc_c = 1'b0;
          end
        end else begin
          lane_dig[k][i] = lane_dig[k-1][i];
        end
      end
      lane_co[k] = lane_co[k-1] | inc_c;
    end
  end

  always_comb begin
    cand_data = '0;
    pop       = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      pop = pop + {63'b0, ~lane_co[k]};
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        if (run && !lane_co[k] && (i < 32'(cur_len_q)))
          cand_data[k*LW + (MAX_LEN - 32'(cur_len_q) + i)*8 +: 8] = sym(lane_dig[k][i]);
      end
    end
  end

  assign cand_valid = run;
  assign cand_len   = run ? cur_len_q : '0;
  assign cand_mask  = run ? ~lane_co[LANES-1:0] : '0;
  assign busy       = run;
  assign done       = (state_q == S_DONE);
  assign hit_stop   = hit_stop_q;
  assign cfg_err    = cfg_err_q;
  assign count      = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cur_len_q  <= '0;
      max_len_q  <= '0;
      count_q    <= '0;
      hit_stop_q <= 1'b0;
      cfg_err_q  <= 1'b0;
      for (int unsigned i = 0; i < MAX_LEN; i++) dig_q[i] <= '0;
    end else if (abort) begin
      state_q <= S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            count_q    <= '0;
            hit_stop_q <= 1'b0;
            if (cfg_ok) begin
              cfg_err_q <= 1'b0;
              cur_len_q <= cfg_min_len;
              max_len_q <= cfg_max_len;
              for (int unsigned i = 0; i < MAX_LEN; i++) dig_q[i] <= '0;
              state_q   <= S_RUN;
            end else begin
              cfg_err_q <= 1'b1;
              state_q   <= S_DONE;
            end
          end
        end
        S_RUN: begin
          if (accept) begin
            count_q <= count_q + pop;
            if (!exhausted) begin
              dig_q <= lane_dig[LANES];
            end else if (cur_len_q < max_len_q) begin
              cur_len_q <= cur_len_q + 4'd1;
              for (int unsigned i = 0; i < MAX_LEN; i++) dig_q[i] <= '0;
            end else begin
              state_q <= S_DONE;
            end
          end
          if (hit_in) begin
            state_q    <= S_DONE;
            hit_stop_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pw_candidate_gen.sv
// Self-checking bench for pw_candidate_gen: a string-index reference model predicts
// every beat, mask, length, count and status flag cycle by cycle.
module tb_pw_candidate_gen;

  localparam int ML = 8;
  localparam int LN = 4;
  localparam int DWID = LN * ML * 8;
  localparam string CHARS = "abcdefghijklmnopqrstuvwxyzABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789";

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic [3:0]      cfg_min_len = '0;
  logic [3:0]      cfg_max_len = '0;
  logic            hit_in = 1'b0;
  logic            cand_valid;
  logic            cand_ready = 1'b0;
  logic [DWID-1:0] cand_data;
  logic [3:0]      cand_len;
  logic [LN-1:0]   cand_mask;
  logic            busy, done, hit_stop, cfg_err;
  logic [63:0]     count;

  int n_tests = 0;
  int n_fail  = 0;

  bit              m_run, m_done, m_hit, m_err;
  int unsigned     m_len, m_max;
  longint unsigned m_n, m_count;

  pw_candidate_gen #(.MAX_LEN(ML), .CHARSET_SIZE(62), .LANES(LN)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_min_len(cfg_min_len), .cfg_max_len(cfg_max_len), .hit_in(hit_in),
    .cand_valid(cand_valid), .cand_ready(cand_ready), .cand_data(cand_data),
    .cand_len(cand_len), .cand_mask(cand_mask), .busy(busy), .done(done),
    .hit_stop(hit_stop), .cfg_err(cfg_err), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic longint unsigned pow62(input int unsigned e);
    longint unsigned p = 1;
    for (int i = 0; i < int'(e); i++) p = p * 62;
    return p;
  endfunction

  function automatic logic [LN-1:0] exp_mask(input longint unsigned n, input int unsigned len);
    logic [LN-1:0] m = '0;
    for (int k = 0; k < LN; k++) m[k] = (n + longint'(k) < pow62(len));
    return m;
  endfunction

  function automatic logic [255:0] exp_data(input longint unsigned n, input int unsigned len);
    logic [255:0] d = '0;
    longint unsigned v;
    for (int k = 0; k < LN; k++) begin
      if (n + longint'(k) < pow62(len)) begin
        for (int j = 0; j < int'(len); j++) begin
          v = ((n + longint'(k)) / pow62(len - 1 - j)) % 62;
          d[k*64 + (7-j)*8 +: 8] = CHARS[int'(v)];
        end
      end
    end
    return d;
  endfunction

  function automatic void model_reset();
    m_run = 0; m_done = 0; m_hit = 0; m_err = 0;
    m_len = 0; m_max = 0; m_n = 0; m_count = 0;
  endfunction

  // One cycle: check current outputs against the model, drive inputs, advance the model.
  task automatic tick(input bit s, input bit a, input bit h, input bit r,
                      input logic [3:0] mn, input logic [3:0] mx);
    longint unsigned tot;
    @(negedge clk);
    check("valid", cand_valid, m_run);
    check("busy", busy, m_run);
    check("done", done, m_done);
    check("hit_stop", hit_stop, m_hit);
    check("cfg_err", cfg_err, m_err);
    check("count", count, m_count);
    if (m_run) begin
      check("len", cand_len, m_len);
      check("mask", cand_mask, exp_mask(m_n, m_len));
      check("data", cand_data, exp_data(m_n, m_len));
    end
    start = s; abort = a; hit_in = h; cand_ready = r;
    cfg_min_len = mn; cfg_max_len = mx;
    if (a) begin
      m_run = 0; m_done = 0;
    end else if (!m_run) begin
      if (s) begin
        m_count = 0; m_hit = 0;
        if (mn >= 1 && mn <= mx && int'(mx) <= ML) begin
          m_err = 0; m_run = 1; m_done = 0; m_len = mn; m_max = mx; m_n = 0;
        end else begin
          m_err = 1; m_done = 1;
        end
      end
    end else begin
      if (r) begin
        tot = pow62(m_len);
        for (int k = 0; k < LN; k++) if (m_n + longint'(k) < tot) m_count++;
        if (m_n + LN >= tot) begin
          if (m_len < m_max) begin m_len++; m_n = 0; end
          else begin m_run = 0; m_done = 1; end
        end else begin
          m_n = m_n + LN;
        end
      end
      if (h) begin m_run = 0; m_done = 1; m_hit = 1; end
    end
  endtask

  task automatic session(input int mn, input int mx, input int rdy_pct, input int hit_beat,
                         input bit chaos, input int budget);
    int cyc;
    bit r, h, s;
    tick(1'b1, 1'b0, 1'b0, 1'b0, 4'(mn), 4'(mx));
    cyc = 0;
    while (m_run && cyc < budget) begin
      r = ($urandom_range(99) < rdy_pct);
      h = (hit_beat >= 0) && r && (m_n == longint'(hit_beat) * LN);
      s = 1'b0;
      if (chaos) begin
        h = h | ($urandom_range(299) == 0);
        s = ($urandom_range(19) == 0);
      end
      tick(s, 1'b0, h, r, 4'($urandom), 4'($urandom));
      cyc++;
    end
    if (m_run) check("timeout", 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] saved;
    int guard;
    model_reset();
    tick(0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    tick(0, 0, 0, 0, 0, 0);

    // Single length, full-rate: 16 beats, explicit first and last beat.
    tick(1, 0, 0, 0, 4'd1, 4'd1);
    for (int b = 0; b < 16; b++) begin
      tick(0, 0, 0, 1, 4'd0, 4'd0);
      if (b == 0) begin
        check("t1_beat0", cand_data, {8'h64, 56'h0, 8'h63, 56'h0, 8'h62, 56'h0, 8'h61, 56'h0});
        check("t1_mask0", cand_mask, 4'b1111);
      end
      if (b == 15) begin
        check("t1_beat15", cand_data, {128'h0, 8'h39, 56'h0, 8'h38, 56'h0});
        check("t1_mask15", cand_mask, 4'b0011);
      end
    end
    tick(0, 0, 0, 0, 4'd0, 4'd0);
    check("t1_done", done, 1'b1);
    check("t1_count", count, 64'd62);

    // Length roll-over 1..2.
    session(1, 2, 100, -1, 0, 2000);
    check("t2_count", count, 64'd3906);
    check("t2_hit_stop", hit_stop, 1'b0);

    // Backpressure on length 2.
    session(2, 2, 50, -1, 0, 8000);
    check("t3_count", count, 64'd3844);

    // Hit coinciding with the accept of beat 5.
    session(3, 3, 100, 5, 0, 100);
    check("t4_count", count, 64'd24);
    check("t4_hit_stop", hit_stop, 1'b1);
    check("t4_valid", cand_valid, 1'b0);

    // Illegal configurations.
    tick(1, 0, 0, 1, 4'd0, 4'd2);
    tick(0, 0, 0, 1, 4'd0, 4'd0);
    check("t5a_cfg_err", cfg_err, 1'b1);
    check("t5a_done", done, 1'b1);
    tick(0, 0, 0, 1, 4'd0, 4'd0);
    tick(1, 0, 0, 1, 4'd3, 4'd2);
    tick(0, 0, 0, 1, 4'd0, 4'd0);
    check("t5b_cfg_err", cfg_err, 1'b1);
    check("t5b_valid", cand_valid, 1'b0);
    tick(0, 0, 0, 1, 4'd0, 4'd0);

    // Abort mid-run, then restart from "a".
    tick(1, 0, 0, 0, 4'd2, 4'd2);
    for (int i = 0; i < 20; i++) tick(0, 0, 0, 1'($urandom_range(1)), 4'd0, 4'd0);
    saved = m_count;
    tick(0, 1, 0, 0, 4'd0, 4'd0);
    tick(0, 0, 0, 0, 4'd0, 4'd0);
    check("t6_done", done, 1'b0);
    check("t6_busy", busy, 1'b0);
    check("t6_count_held", count, saved);
    tick(1, 0, 0, 0, 4'd1, 4'd1);
    tick(0, 0, 0, 0, 4'd0, 4'd0);
    check("t6_restart", cand_data[63:0], 64'h6100_0000_0000_0000);
    guard = 0;
    while (m_run && guard < 100) begin
      tick(0, 0, 0, 1, 4'd0, 4'd0);
      guard++;
    end
    if (m_run) check("t6_timeout", 1'b1, 1'b0);
    tick(0, 0, 0, 0, 4'd0, 4'd0);

    // Asynchronous reset between edges mid-run.
    tick(1, 0, 0, 0, 4'd2, 4'd2);
    for (int i = 0; i < 10; i++) tick(0, 0, 0, 1, 4'd0, 4'd0);
    #1 rst = 1'b1;
    #1;
    check("rst_valid", cand_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_count", count, 64'd0);
    check("rst_data", cand_data, '0);
    check("rst_mask", cand_mask, '0);
    check("rst_len", cand_len, '0);
    model_reset();
    tick(0, 0, 0, 0, 4'd0, 4'd0);
    rst = 1'b0;
    tick(0, 0, 0, 0, 4'd0, 4'd0);

    // Randomized sessions with stray starts, random hits and random configs.
    for (int s = 0; s < 3; s++)
      session(int'($urandom_range(2, 0)), int'($urandom_range(2, 1)),
              int'($urandom_range(100, 30)), -1, 1, 20000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
